// File: rtl/controlador_nivel_temperatura.sv
// Round-robin scan controller sharing one temperature comparator across N sensors,
// with per-sensor debounce of the comparator level, maximum level and alarm flag.
module controlador_nivel_temperatura #(
  parameter int N_SENSORES = 4,
  parameter int K_CONFIRMA = 3,
  parameter int TIMEOUT    = 16,
  parameter int LIM_ALARME = 5
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          iniciar,
  input  logic                          parar,
  output logic [$clog2(N_SENSORES)-1:0] sel_sensor,
  output logic                          medir,
  input  logic                          pronto,
  input  logic [2:0]                    nivel,
  output logic [3*N_SENSORES-1:0]       niveis,
  output logic [2:0]                    nivel_max,
  output logic                          alarme,
  output logic                          atualizado,
  output logic                          ocupado,
  output logic                          erro_timeout
);

  localparam int SEL_W = $clog2(N_SENSORES);
  localparam int CNT_W = $clog2(K_CONFIRMA + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {OCIOSO, MEDE, ESPERA, AVALIA} estado_t;

  estado_t          r_estado, w_prox;
  logic [SEL_W-1:0] r_sel, w_sel_prox;
  logic [TMO_W-1:0] r_cont_tmo;
  logic             r_parar, r_erro, r_atualizado;
  logic             w_inicia, w_avanca, w_amostra, w_timeout, w_parar_ef;

  logic [2:0]       r_conf [N_SENSORES];
  logic [2:0]       r_cand [N_SENSORES];
  logic [CNT_W-1:0] r_cnt  [N_SENSORES];
  logic [2:0]       w_conf_n, w_cand_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_muda;

  // A stop request seen in the very cycle the sensor completes still counts.
  assign w_parar_ef = r_parar | parar;
  assign w_sel_prox = (r_sel == SEL_W'(N_SENSORES - 1)) ? '0 : r_sel + 1'b1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_prox    = r_estado;
    w_inicia  = 1'b0;
    w_avanca  = 1'b0;
    w_amostra = 1'b0;
    w_timeout = 1'b0;
    case (r_estado)
      OCIOSO: if (iniciar && !parar) begin
        w_inicia = 1'b1;
        w_prox   = MEDE;
      end
      MEDE:   w_prox = ESPERA;
      ESPERA: begin
        if (pronto) begin
          w_prox = AVALIA;
        end else if (r_cont_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_avanca  = 1'b1;
        end
      end
      AVALIA: begin
        w_amostra = 1'b1;
        w_avanca  = 1'b1;
      end
      default: w_prox = OCIOSO;
    endcase
    if (w_avanca) w_prox = w_parar_ef ? OCIOSO : MEDE;
  end

  // Debounce step for the currently selected sensor.
  always_comb begin
    w_conf_n = r_conf[r_sel];
    w_cand_n = r_cand[r_sel];
    w_cnt_n  = r_cnt[r_sel];
    w_muda   = 1'b0;
    if (nivel == r_conf[r_sel]) begin
      w_cnt_n = '0;
    end else begin
      w_cand_n = nivel;
      w_cnt_n  = (nivel == r_cand[r_sel]) ? r_cnt[r_sel] + 1'b1 : CNT_W'(1);
      if (w_cnt_n == CNT_W'(K_CONFIRMA)) begin
        w_conf_n = nivel;
        w_cnt_n  = '0;
        w_muda   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado     <= OCIOSO;
      r_sel        <= '0;
      r_cont_tmo   <= '0;
      r_parar      <= 1'b0;
      r_erro       <= 1'b0;
      r_atualizado <= 1'b0;
    end else begin
      r_estado     <= w_prox;
      r_atualizado <= w_amostra & w_muda;
      if (w_inicia)      r_sel <= '0;
      else if (w_avanca) r_sel <= w_sel_prox;
      if (r_estado == MEDE)                r_cont_tmo <= '0;
      else if (r_estado == ESPERA && !pronto) r_cont_tmo <= r_cont_tmo + 1'b1;
      if (w_inicia)                            r_parar <= 1'b0;
      else if (r_estado != OCIOSO && parar)    r_parar <= 1'b1;
      if (w_inicia)       r_erro <= 1'b0;
      else if (w_timeout) r_erro <= 1'b1;
    end
  end

  // NOTE: the debounce arrays are a handful of flops, not a RAM, so they take the async reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SENSORES; i++) begin
        r_conf[i] <= '0;
        r_cand[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else if (w_amostra) begin
      r_conf[r_sel] <= w_conf_n;
      r_cand[r_sel] <= w_cand_n;
      r_cnt[r_sel]  <= w_cnt_n;
    end
  end

  always_comb begin
    niveis    = '0;
    nivel_max = '0;
    for (int i = 0; i < N_SENSORES; i++) begin
      niveis[3*i +: 3] = r_conf[i];
      if (r_conf[i] > nivel_max) nivel_max = r_conf[i];
    end
  end

  assign alarme       = int'(nivel_max) >= LIM_ALARME;
  assign sel_sensor   = r_sel;
  assign medir        = (r_estado == MEDE);
  assign ocupado      = (r_estado != OCIOSO);
  assign erro_timeout = r_erro;
  assign atualizado   = r_atualizado;

endmodule

// File: tb/tb_controlador_nivel_temperatura.sv
// Self-checking bench: randomized sensor responses against a history-based model
// of the scan order, debounce confirmation, timeout and stop behaviour.
module tb_controlador_nivel_temperatura;
  localparam int N = 4, K = 3, TMO = 16, LIM = 5;

  logic        clock = 1'b0, reset_n = 1'b0, iniciar = 1'b0, parar = 1'b0;
  logic        pronto = 1'b0;
  logic [2:0]  nivel = '0;
  logic [1:0]  sel_sensor;
  logic        medir, alarme, atualizado, ocupado, erro_timeout;
  logic [11:0] niveis;
  logic [2:0]  nivel_max;

  int total = 0, bad = 0;

  // Model: confirmed levels, full per-sensor sample history, expected scan pointer.
  logic [2:0] m_conf [N];
  logic [2:0] hist [N][512];
  int         nh [N];
  int         exp_sel;
  bit         exp_erro;

  controlador_nivel_temperatura #(
    .N_SENSORES(N), .K_CONFIRMA(K), .TIMEOUT(TMO), .LIM_ALARME(LIM)
  ) dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .parar(parar),
    .sel_sensor(sel_sensor), .medir(medir), .pronto(pronto), .nivel(nivel),
    .niveis(niveis), .nivel_max(nivel_max), .alarme(alarme),
    .atualizado(atualizado), .ocupado(ocupado), .erro_timeout(erro_timeout)
  );

  always #5 clock = ~clock;

  task automatic modelo_reset();
    for (int i = 0; i < N; i++) begin
      m_conf[i] = '0;
      nh[i] = 0;
    end
    exp_sel  = 0;
    exp_erro = 1'b0;
  endtask

  // A level is confirmed when the last K samples of that sensor all equal it.
  task automatic modelo_amostra(input int s, input logic [2:0] v, output bit muda);
    bit todos;
    hist[s][nh[s]] = v;
    nh[s]++;
    muda = 1'b0;
    if (v != m_conf[s] && nh[s] >= K) begin
      todos = 1'b1;
      for (int j = 1; j <= K; j++) if (hist[s][nh[s]-j] != v) todos = 1'b0;
      if (todos) begin
        m_conf[s] = v;
        muda = 1'b1;
      end
    end
  endtask

  function automatic logic [11:0] exp_niveis();
    logic [11:0] r = '0;
    for (int i = 0; i < N; i++) r[3*i +: 3] = m_conf[i];
    return r;
  endfunction

  function automatic logic [2:0] exp_max();
    logic [2:0] m = '0;
    for (int i = 0; i < N; i++) if (m_conf[i] > m) m = m_conf[i];
    return m;
  endfunction

  task automatic iniciar_scan();
    @(negedge clock);
    iniciar = 1'b1;
    parar   = 1'b0;
    @(negedge clock);
    iniciar  = 1'b0;
    exp_sel  = 0;
    exp_erro = 1'b0;
    total++;
    if ({ocupado, medir, sel_sensor, erro_timeout} !== 5'b11_00_0) begin
      bad++;
      $display("FAIL start: ocupado/medir/sel/erro=%b required 11000",
               {ocupado, medir, sel_sensor, erro_timeout});
    end
  endtask

  // One sensor visit: respond after d ESPERA cycles with level v, or never (tmo).
  task automatic visita(input logic [2:0] v, input int d, input bit tmo, input bit pp);
    int budget = 0;
    bit muda = 1'b0;
    while (medir !== 1'b1 && budget < 40) begin
      @(negedge clock);
      budget++;
    end
    total++;
    if (medir !== 1'b1) begin
      bad++;
      $display("FAIL wait_medir: medir=%b required 1 within 40 cycles", medir);
      return;
    end
    total++;
    if (sel_sensor !== 2'(exp_sel)) begin
      bad++;
      $display("FAIL scan_sel: sel_sensor=%0d required %0d", sel_sensor, exp_sel);
    end
    @(negedge clock);
    total++;
    if ({medir, ocupado} !== 2'b01) begin
      bad++;
      $display("FAIL medir_pulse: medir/ocupado=%b required 01", {medir, ocupado});
    end
    if (pp) parar = 1'b1;
    if (tmo) begin
      repeat (TMO - 1) begin
        @(negedge clock);
        parar = 1'b0;
      end
      total++;
      if ({medir, sel_sensor} !== {1'b0, 2'(exp_sel)}) begin
        bad++;
        $display("FAIL tmo_early: medir/sel=%b required %b", {medir, sel_sensor},
                 {1'b0, 2'(exp_sel)});
      end
      @(negedge clock);
      exp_erro = 1'b1;
    end else begin
      repeat (d) begin
        @(negedge clock);
        parar = 1'b0;
      end
      pronto = 1'b1;
      nivel  = v;
      @(negedge clock);
      pronto = 1'b0;
      parar  = 1'b0;
      total++;
      if ({ocupado, medir, sel_sensor} !== {2'b10, 2'(exp_sel)}) begin
        bad++;
        $display("FAIL avalia: ocupado/medir/sel=%b required %b",
                 {ocupado, medir, sel_sensor}, {2'b10, 2'(exp_sel)});
      end
      @(negedge clock);
      modelo_amostra(exp_sel, v, muda);
    end
    exp_sel = (exp_sel + 1) % N;
    total++;
    if (atualizado !== muda) begin
      bad++;
      $display("FAIL atualizado: got %b required %b", atualizado, muda);
    end
    total++;
    if ({niveis, nivel_max, alarme} !== {exp_niveis(), exp_max(), exp_max() >= 3'(LIM)}) begin
      bad++;
      $display("FAIL niveis: niveis/max/alarme=%h/%0d/%b required %h/%0d/%b", niveis,
               nivel_max, alarme, exp_niveis(), exp_max(), exp_max() >= 3'(LIM));
    end
    total++;
    if ({erro_timeout, sel_sensor, ocupado, medir} !== {exp_erro, 2'(exp_sel), !pp, !pp}) begin
      bad++;
      $display("FAIL after_visit: erro/sel/ocupado/medir=%b required %b",
               {erro_timeout, sel_sensor, ocupado, medir}, {exp_erro, 2'(exp_sel), !pp, !pp});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    modelo_reset();
    repeat (6) begin
      @(negedge clock);
      {iniciar, parar, pronto} = 3'($urandom_range(0, 7));
      nivel = 3'($urandom_range(0, 7));
      total++;
      if ({sel_sensor, medir, niveis, nivel_max, alarme, atualizado, ocupado, erro_timeout} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: sel=%0d medir=%b niveis=%h max=%0d ocupado=%b required all 0",
                 sel_sensor, medir, niveis, nivel_max, ocupado);
      end
    end
    @(negedge clock);
    {iniciar, parar, pronto} = 3'b000;
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clock);
      pronto = 1'($urandom_range(0, 1));
      total++;
      if ({medir, ocupado} !== 2'b00) begin
        bad++;
        $display("FAIL idle_after_reset: medir/ocupado=%b required 00", {medir, ocupado});
      end
    end
    pronto = 1'b0;
  endtask

  task automatic test_scan_order();
    iniciar_scan();
    repeat (6) visita(3'd0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_confirmacao();
    int n2 = 0;
    while (n2 < 3) begin
      if (exp_sel == 2) begin
        n2++;
        visita(3'd5, 0, 1'b0, 1'b0);
        if (n2 == 2) begin
          total++;
          if (niveis[8:6] !== 3'd0) begin
            bad++;
            $display("FAIL confirm_early: niveis[8:6]=%0d required 0", niveis[8:6]);
          end
        end
      end else begin
        visita(3'd0, 0, 1'b0, 1'b0);
      end
    end
    total++;
    if ({niveis[8:6], nivel_max, alarme} !== {3'd5, 3'd5, 1'b1}) begin
      bad++;
      $display("FAIL confirm: niveis[8:6]/max/alarme=%0d/%0d/%b required 5/5/1",
               niveis[8:6], nivel_max, alarme);
    end
  endtask

  task automatic test_debounce();
    logic [2:0] seq [6] = '{3'd4, 3'd4, 3'd3, 3'd4, 3'd4, 3'd4};
    int k = 0;
    while (k < 6) begin
      if (exp_sel == 0) begin
        visita(seq[k], $urandom_range(0, 3), 1'b0, 1'b0);
        k++;
        if (k == 5) begin
          total++;
          if (niveis[2:0] !== 3'd0) begin
            bad++;
            $display("FAIL debounce_hold: niveis[2:0]=%0d required 0", niveis[2:0]);
          end
        end
      end else begin
        visita(m_conf[exp_sel], $urandom_range(0, 3), 1'b0, 1'b0);
      end
    end
    total++;
    if (niveis[2:0] !== 3'd4) begin
      bad++;
      $display("FAIL debounce_confirm: niveis[2:0]=%0d required 4", niveis[2:0]);
    end
  endtask

  task automatic test_timeout();
    while (exp_sel != 1) visita(m_conf[exp_sel], 0, 1'b0, 1'b0);
    visita(3'd7, 0, 1'b1, 1'b0);
    repeat (3) visita(m_conf[exp_sel], $urandom_range(0, 2), 1'b0, 1'b0);
  endtask

  task automatic test_parar();
    while (exp_sel != 3) visita(m_conf[exp_sel], 0, 1'b0, 1'b0);
    visita(3'd2, $urandom_range(0, 3), 1'b0, 1'b1);
    @(negedge clock);
    iniciar = 1'b1;
    parar   = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    parar   = 1'b0;
    total++;
    if ({ocupado, erro_timeout} !== 2'b01) begin
      bad++;
      $display("FAIL start_with_stop: ocupado/erro=%b required 01", {ocupado, erro_timeout});
    end
    iniciar_scan();
  endtask

  task automatic test_random();
    logic [2:0] v;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 3'd0;
        1:       v = 3'd6;
        2:       v = m_conf[exp_sel];
        default: v = 3'($urandom_range(0, 7));
      endcase
      visita(v, $urandom_range(0, 6), $urandom_range(0, 9) == 0, 1'b0);
    end
  endtask

  task automatic test_abort();
    int budget = 0;
    while (medir !== 1'b1 && budget < 40) begin
      @(negedge clock);
      budget++;
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    modelo_reset();
    total++;
    if ({sel_sensor, medir, niveis, nivel_max, alarme, atualizado, ocupado, erro_timeout} !== '0) begin
      bad++;
      $display("FAIL abort: sel=%0d niveis=%h max=%0d ocupado=%b erro=%b required all 0",
               sel_sensor, niveis, nivel_max, ocupado, erro_timeout);
    end
    @(negedge clock);
    reset_n = 1'b1;
    pronto  = 1'b1;
    repeat (3) @(negedge clock);
    pronto = 1'b0;
    total++;
    if ({ocupado, medir, niveis} !== '0) begin
      bad++;
      $display("FAIL abort_idle: ocupado/medir=%b niveis=%h required 0", {ocupado, medir}, niveis);
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_confirmacao();
    test_debounce();
    test_timeout();
    test_parar();
    test_random();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
